ab_link_scheduler: RTL and testbench

Time-multiplexes one shared physical link between the A-to-B and B-to-A data streams of the moduleA/moduleB pair. Each side presents beats with a valid/ready handshake. The scheduler grants the link round-robin with a bounded burst length and drives a single registered bus stage carrying the data, a direction flag, the B sideband field and a burst-last marker. It sits between the two endpoints and the link serializer.

---
 rtl/ab_link_pkg.sv | 12 +
 rtl/ab_link_out_stage.sv | 45 ++++
 rtl/ab_link_scheduler.sv | 89 ++++++++
 tb/tb_ab_link_scheduler.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ab_link_pkg.sv
// ab_link_pkg: shared types, direction codes and width helpers for the A/B link scheduler
package ab_link_pkg;
  typedef enum logic [1:0] {IDLE, SERVE_A, SERVE_B} state_e;
  localparam logic DIR_A2B = 1'b0;
  localparam logic DIR_B2A = 1'b1;
  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
  function automatic int cnt_w(input int mb);
    return $clog2(mb + 1);
  endfunction
endpackage

// File: rtl/ab_link_out_stage.sv
// ab_link_out_stage: single-entry registered valid/ready stage holding {dir, last, extra, data}
//   load/in_*  : beat to capture (only asserted while out_free)
//   out_*      : registered beat presented downstream, out_ready accepts it
//   out_free   : stage can take a new beat this cycle
module ab_link_out_stage
  import ab_link_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int EXTRA_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               in_dir,
  input  logic               in_last,
  input  logic [EXTRA_W-1:0] in_extra,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               out_ready,
  output logic               out_valid,
  output logic               out_dir,
  output logic               out_last,
  output logic [EXTRA_W-1:0] out_extra,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_free
);
  localparam int BEAT_W = DATA_W + EXTRA_W + 2;
  logic              valid_q, valid_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  assign out_free = !valid_q || out_ready;
  always_comb begin
    valid_d = load ? 1'b1 : (out_ready ? 1'b0 : valid_q);
    beat_d  = load ? {in_dir, in_last, in_extra, in_data} : beat_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      beat_q  <= '0;
    end else begin
      valid_q <= valid_d;
      beat_q  <= beat_d;
    end
  end
  assign out_valid = valid_q;
  assign {out_dir, out_last, out_extra, out_data} = beat_q;
endmodule

// File: rtl/ab_link_scheduler.sv
// ab_link_scheduler: round-robin, burst-bounded time-multiplexing of A->B and B->A beats onto one link
//   a_*/b_*   : per-direction valid/ready beat inputs (b_extra travels with B beats)
//   bus_*     : registered shared-link beat (dir 0 = A->B, 1 = B->A), bus_last marks a full burst end
//   busy      : a grant is active
module ab_link_scheduler
  import ab_link_pkg::*;
#(
  parameter  int A2B_W     = 16,
  parameter  int B2A_W     = 8,
  parameter  int EXTRA_W   = 4,
  parameter  int MAX_BURST = 4,
  localparam int BUS_W     = max_w(A2B_W, B2A_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               a_valid,
  output logic               a_ready,
  input  logic [A2B_W-1:0]   a_data,
  input  logic               b_valid,
  output logic               b_ready,
  input  logic [B2A_W-1:0]   b_data,
  input  logic [EXTRA_W-1:0] b_extra,
  output logic               bus_valid,
  input  logic               bus_ready,
  output logic               bus_dir,
  output logic [BUS_W-1:0]   bus_data,
  output logic [EXTRA_W-1:0] bus_extra,
  output logic               bus_last,
  output logic               busy
);
  localparam int CW = cnt_w(MAX_BURST);
  state_e        state_q, state_d;
  logic          last_dir_q, last_dir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_free, serve_b, cur_valid, xfer, last_beat;
  assign serve_b   = state_q == SERVE_B;
  assign cur_valid = serve_b ? b_valid : a_valid;
  assign a_ready   = (state_q == SERVE_A) && out_free;
  assign b_ready   = serve_b && out_free;
  assign xfer      = (a_valid && a_ready) || (b_valid && b_ready);
  assign last_beat = cnt_q == CW'(MAX_BURST - 1);
  assign busy      = state_q != IDLE;
  always_comb begin
    state_d    = state_q;
    last_dir_d = last_dir_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: state_d = (a_valid && b_valid) ? ((last_dir_q == DIR_B2A) ? SERVE_A : SERVE_B) :
                      a_valid ? SERVE_A : b_valid ? SERVE_B : IDLE;
      SERVE_A, SERVE_B:
        // a stalled bus (out_free=0) can neither transfer nor release
        if ((xfer && last_beat) || (out_free && !cur_valid)) begin
          state_d    = IDLE;
          last_dir_d = serve_b ? DIR_B2A : DIR_A2B;
          cnt_d      = '0;
        end else if (xfer) begin
          cnt_d = cnt_q + 1'b1;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_dir_q <= DIR_B2A;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_dir_q <= last_dir_d;
      cnt_q      <= cnt_d;
    end
  end
  ab_link_out_stage #(.DATA_W(BUS_W), .EXTRA_W(EXTRA_W)) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (xfer),
    .in_dir    (serve_b ? DIR_B2A : DIR_A2B),
    .in_last   (last_beat),
    .in_extra  (serve_b ? b_extra : '0),
    .in_data   (serve_b ? BUS_W'(b_data) : BUS_W'(a_data)),
    .out_ready (bus_ready),
    .out_valid (bus_valid),
    .out_dir   (bus_dir),
    .out_last  (bus_last),
    .out_extra (bus_extra),
    .out_data  (bus_data),
    .out_free  (out_free)
  );
endmodule

// File: tb/tb_ab_link_scheduler.sv
// tb_ab_link_scheduler: directed stimulus with a per-cycle behavioural model plus literal beat-sequence checks
module tb_ab_link_scheduler;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  logic        a_valid = 0, b_valid = 0, bus_ready = 1;
  logic [15:0] a_data = 16'h1000;
  logic [7:0]  b_data = 8'hA0;
  logic [3:0]  b_extra = 4'h5;
  logic        a_ready, b_ready, bus_valid, bus_dir, bus_last, busy;
  logic [15:0] bus_data;
  logic [3:0]  bus_extra;
  logic        a1_valid = 0, b1_valid = 0, bus1_ready = 1;
  logic [15:0] a1_data = 16'h2222;
  logic [7:0]  b1_data = 8'h33;
  logic [3:0]  b1_extra = 4'h9;
  logic        a1_ready, b1_ready, bus1_valid, bus1_dir, bus1_last, busy1;
  logic [15:0] bus1_data;
  logic [3:0]  bus1_extra;

  ab_link_scheduler #(.A2B_W(16), .B2A_W(8), .EXTRA_W(4), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_extra(b_extra),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_dir(bus_dir), .bus_data(bus_data),
    .bus_extra(bus_extra), .bus_last(bus_last), .busy(busy));

  ab_link_scheduler #(.A2B_W(16), .B2A_W(8), .EXTRA_W(4), .MAX_BURST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .a_valid(a1_valid), .a_ready(a1_ready), .a_data(a1_data),
    .b_valid(b1_valid), .b_ready(b1_ready), .b_data(b1_data), .b_extra(b1_extra),
    .bus_valid(bus1_valid), .bus_ready(bus1_ready), .bus_dir(bus1_dir), .bus_data(bus1_data),
    .bus_extra(bus1_extra), .bus_last(bus1_last), .busy(busy1));

  int tests = 0;
  int fails = 0;
  bit done = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // own: 0 = no grant, 1 = A holds the link, 2 = B holds the link
  typedef struct {
    int          own;
    bit          last_b;
    int          beats;
    bit          v;
    bit          dir;
    bit          last;
    logic [3:0]  ext;
    logic [15:0] data;
  } mdl_t;

  function automatic mdl_t mreset();
    mdl_t m;
    m.own = 0; m.last_b = 1; m.beats = 0; m.v = 0; m.dir = 0; m.last = 0; m.ext = 0; m.data = 0;
    return m;
  endfunction

  function automatic mdl_t mstep(mdl_t m, int mb, bit av, bit bv, bit br,
                                 logic [15:0] ad, logic [7:0] bd, logic [3:0] be);
    mdl_t n;
    bit free, want, take;
    n = m;
    free = !m.v || br;
    want = (m.own == 1) ? av : (m.own == 2) ? bv : 1'b0;
    take = want && free;
    if (take) begin
      n.v = 1;
      n.dir = (m.own == 2);
      n.data = (m.own == 2) ? {8'h00, bd} : ad;
      n.ext = (m.own == 2) ? be : 4'h0;
      n.last = (m.beats == mb - 1);
    end else if (br) n.v = 0;
    if (m.own == 0) n.own = (av && bv) ? (m.last_b ? 1 : 2) : av ? 1 : bv ? 2 : 0;
    else if ((take && m.beats == mb - 1) || (free && !want)) begin
      n.last_b = (m.own == 2);
      n.own = 0;
      n.beats = 0;
    end else if (take) n.beats = m.beats + 1;
    return n;
  endfunction

  mdl_t m0, m1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 <= mreset();
      m1 <= mreset();
    end else begin
      m0 <= mstep(m0, 4, a_valid, b_valid, bus_ready, a_data, b_data, b_extra);
      m1 <= mstep(m1, 1, a1_valid, b1_valid, bus1_ready, a1_data, b1_data, b1_extra);
    end
  end

  task automatic cmp_inst(input string p, input mdl_t m, input logic brdy,
                          input logic ar, input logic bra, input logic bv, input logic bd,
                          input logic bl, input logic bz, input logic [15:0] dat, input logic [3:0] ex);
    chk({p, "a_ready"}, ar, m.own == 1 && (!m.v || brdy));
    chk({p, "b_ready"}, bra, m.own == 2 && (!m.v || brdy));
    chk({p, "busy"}, bz, m.own != 0);
    chk({p, "bus_valid"}, bv, m.v);
    if (m.v) begin
      chk({p, "bus_dir"}, bd, m.dir);
      chk({p, "bus_data"}, dat, m.data);
      chk({p, "bus_extra"}, ex, m.ext);
      chk({p, "bus_last"}, bl, m.last);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && !done) begin
      cmp_inst("m4_", m0, bus_ready, a_ready, b_ready, bus_valid, bus_dir, bus_last, busy, bus_data, bus_extra);
      cmp_inst("m1_", m1, bus1_ready, a1_ready, b1_ready, bus1_valid, bus1_dir, bus1_last, busy1, bus1_data, bus1_extra);
    end
  end

  typedef struct {
    bit          dir;
    bit          last;
    logic [3:0]  ext;
    logic [15:0] data;
    int          cyc;
  } beat_t;
  beat_t cap[$];
  beat_t cap1[$];
  int cycn = 0;
  always @(posedge clk) cycn <= cycn + 1;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_valid && bus_ready) cap.push_back('{bus_dir, bus_last, bus_extra, bus_data, cycn});
      if (bus1_valid && bus1_ready) cap1.push_back('{bus1_dir, bus1_last, bus1_extra, bus1_data, cycn});
    end
  end

  int a_idx = 0;
  int b_idx = 0;
  task automatic cyc();
    bit ha, hb;
    @(negedge clk);
    ha = a_valid && a_ready;
    hb = b_valid && b_ready;
    @(posedge clk);
    #1;
    if (ha) a_idx++;
    if (hb) b_idx++;
    a_data = 16'h1000 + 16'(a_idx);
    b_data = 8'hA0 | 8'(b_idx & 15);
  endtask

  initial begin
    int abase, bbase, na, nal;
    bit ed;
    repeat (3) cyc();
    chk("rst_bus_valid", bus_valid, 0);
    chk("rst_bus_data", bus_data, 0);
    chk("rst_bus_dir", bus_dir, 0);
    chk("rst_bus_extra", bus_extra, 0);
    chk("rst_bus_last", bus_last, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_busy", busy, 0);
    chk("model_rst_last_b", m0.last_b, 1);
    rst_n = 1;
    repeat (2) cyc();

    // A alone, two bursts of four with one idle bubble between them
    cap.delete();
    a_valid = 1;
    for (int t = 0; t < 100 && a_idx < 8; t++) cyc();
    chk("s1_accepts", a_idx, 8);
    a_valid = 0;
    repeat (4) cyc();
    chk("s1_beats", cap.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk("s1_data", cap[i].data, 32'h1000 + i);
      chk("s1_last", cap[i].last, (i == 3 || i == 7));
      chk("s1_dir", cap[i].dir, 0);
    end
    chk("s1_inburst_gap", cap[1].cyc - cap[0].cyc, 1);
    chk("s1_bubble_gap", cap[4].cyc - cap[3].cyc, 2);

    // contention: A served last, so B bursts first, then alternating
    cap.delete();
    abase = a_idx;
    bbase = b_idx;
    a_valid = 1;
    b_valid = 1;
    for (int t = 0; t < 200 && cap.size() < 16; t++) cyc();
    a_valid = 0;
    b_valid = 0;
    repeat (4) cyc();
    for (int k = 0; k < 16; k++) begin
      ed = ((k / 4) % 2) == 0;
      chk("s2_dir", cap[k].dir, ed);
      chk("s2_last", cap[k].last, (k % 4) == 3);
      if (ed) begin
        chk("s2_b_data", cap[k].data, 32'hA0 | ((bbase + (k / 8) * 4 + k % 4) & 15));
        chk("s2_b_extra", cap[k].ext, 5);
      end else begin
        chk("s2_a_data", cap[k].data, 32'h1000 + abase + (k / 8) * 4 + k % 4);
        chk("s2_a_extra", cap[k].ext, 0);
      end
    end

    // downstream stall mid-burst
    cap.delete();
    abase = a_idx;
    a_valid = 1;
    for (int t = 0; t < 100 && a_idx < abase + 2; t++) cyc();
    bus_ready = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("s3_stall_valid", bus_valid, 1);
      chk("s3_stall_a_ready", a_ready, 0);
      chk("s3_stall_busy", busy, 1);
      chk("s3_stall_data", bus_data, 32'h1000 + abase + 1);
    end
    bus_ready = 1;
    for (int t = 0; t < 100 && a_idx < abase + 4; t++) cyc();
    a_valid = 0;
    repeat (4) cyc();
    chk("s3_beats", cap.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("s3_data", cap[i].data, 32'h1000 + abase + i);
      chk("s3_last", cap[i].last, i == 3);
    end

    // A gap after two beats hands the link to B
    cap.delete();
    abase = a_idx;
    bbase = b_idx;
    a_valid = 1;
    for (int t = 0; t < 100 && a_idx < abase + 2; t++) cyc();
    a_valid = 0;
    b_valid = 1;
    for (int t = 0; t < 100 && b_idx < bbase + 4; t++) cyc();
    b_valid = 0;
    repeat (4) cyc();
    na = 0;
    nal = 0;
    foreach (cap[i]) if (!cap[i].dir) begin na++; if (cap[i].last) nal++; end
    chk("s4_a_beats", na, 2);
    chk("s4_a_last", nal, 0);
    chk("s4_beats", cap.size(), 6);
    chk("s4_b_after", cap[2].dir, 1);
    chk("s4_b_last", cap[5].last, 1);

    // asynchronous reset with a beat in the bus stage
    a_valid = 1;
    for (int t = 0; t < 100 && !bus_valid; t++) cyc();
    chk("s5_pre_valid", bus_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("s5_bus_valid", bus_valid, 0);
    chk("s5_bus_data", bus_data, 0);
    chk("s5_bus_dir", bus_dir, 0);
    chk("s5_bus_extra", bus_extra, 0);
    chk("s5_bus_last", bus_last, 0);
    chk("s5_a_ready", a_ready, 0);
    chk("s5_busy", busy, 0);
    b_valid = 1;
    @(posedge clk);
    #1;
    rst_n = 1;
    cap.delete();
    for (int t = 0; t < 100 && cap.size() < 1; t++) cyc();
    chk("s5_first_tie_a", cap[0].dir, 0);
    a_valid = 0;
    b_valid = 0;
    repeat (6) cyc();

    // MAX_BURST=1 instance: strict alternation, bubble between grants
    cap1.delete();
    a1_valid = 1;
    b1_valid = 1;
    for (int t = 0; t < 200 && cap1.size() < 12; t++) cyc();
    a1_valid = 0;
    b1_valid = 0;
    repeat (4) cyc();
    for (int k = 0; k < 12; k++) begin
      chk("s6_dir", cap1[k].dir, k % 2);
      chk("s6_last", cap1[k].last, 1);
      chk("s6_data", cap1[k].data, (k % 2) ? 32'h33 : 32'h2222);
      chk("s6_extra", cap1[k].ext, (k % 2) ? 9 : 0);
      if (k > 0) chk("s6_gap", cap1[k].cyc - cap1[k-1].cyc, 2);
    end

    done = 1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
